// File: rtl/tank_pkg.sv
// Shared types and constants for the turret controller: fire-state encoding,
// angle index values and default key codes.
package tank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FLIGHT = 2'd2,
        ST_COOL   = 2'd3
    } fire_state_t;

    localparam logic [3:0] ANG_270 = 4'd0;
    localparam logic [3:0] ANG_300 = 4'd1;
    localparam logic [3:0] ANG_315 = 4'd2;
    localparam logic [3:0] ANG_330 = 4'd3;
    localparam logic [3:0] ANG_0   = 4'd4;
    localparam logic [3:0] ANG_30  = 4'd5;
    localparam logic [3:0] ANG_45  = 4'd6;
    localparam logic [3:0] ANG_60  = 4'd7;
    localparam logic [3:0] ANG_90  = 4'd8;

    localparam logic [7:0] KEY_NONE      = 8'h00;
    localparam logic [7:0] KEY_UP_CODE   = 8'h1A;
    localparam logic [7:0] KEY_DOWN_CODE = 8'h16;
    localparam logic [7:0] KEY_FIRE_CODE = 8'h2C;

    function automatic logic [8:0] angle_to_onehot(input logic [3:0] idx);
        return 9'd1 << idx;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Press detection and frame-based auto-repeat for a single key; emits a
// one-cycle step on the press and every REPEAT_FRAMES frame ticks while held.
module key_repeat #(
    parameter logic [7:0] KEY           = 8'h1A,
    parameter int         REPEAT_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] keycode,
    input  logic [7:0] prev_keycode,
    input  logic       frame_tick,
    output logic       step
);

    localparam logic [7:0] LAST_COUNT = 8'(REPEAT_FRAMES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       active_q, active_d;
    logic       held, press;

    assign held  = (keycode == KEY);
    assign press = enable && held && (prev_keycode != KEY);

    // Repeat only runs after a genuine press, so a key held across reset stays inert.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        step     = 1'b0;
        if (!held) begin
            cnt_d    = 8'd0;
            active_d = 1'b0;
        end else if (press) begin
            cnt_d    = 8'd0;
            active_d = 1'b1;
            step     = 1'b1;
        end else if (active_q && frame_tick) begin
            if (cnt_q == LAST_COUNT) begin
                cnt_d = 8'd0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/turret_fire_ctrl.sv
// Turret aiming and fire sequencing: keyboard-driven angle stepping with
// auto-repeat, plus a request/flight/cooldown fire state machine.
module turret_fire_ctrl
    import tank_pkg::*;
#(
    parameter logic [7:0] KEY_UP          = KEY_UP_CODE,
    parameter logic [7:0] KEY_DOWN        = KEY_DOWN_CODE,
    parameter logic [7:0] KEY_FIRE        = KEY_FIRE_CODE,
    parameter int         REPEAT_FRAMES   = 8,
    parameter int         COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       fire_ack,
    input  logic       proj_done,
    output logic [3:0] angle_idx,
    output logic [8:0] angle_onehot,
    output logic       fire_req,
    output logic [3:0] fire_angle,
    output logic       busy
);

    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

    logic [7:0]  prev_kc_q;
    logic        started_q;
    logic        up_step, dn_step, fire_press;
    fire_state_t state_q, state_d;
    logic [7:0]  cool_q, cool_d;
    logic [3:0]  angle_q, angle_d;
    logic [3:0]  fire_angle_q, fire_angle_d;
    logic [8:0]  onehot_q, onehot_d;
    logic        fire_req_q, fire_req_d;
    logic        busy_q, busy_d;

    key_repeat #(.KEY(KEY_UP), .REPEAT_FRAMES(REPEAT_FRAMES)) u_up (
        .clk(Clk), .rst(Reset), .enable(started_q), .keycode(keycode),
        .prev_keycode(prev_kc_q), .frame_tick(frame_tick), .step(up_step)
    );

    key_repeat #(.KEY(KEY_DOWN), .REPEAT_FRAMES(REPEAT_FRAMES)) u_down (
        .clk(Clk), .rst(Reset), .enable(started_q), .keycode(keycode),
        .prev_keycode(prev_kc_q), .frame_tick(frame_tick), .step(dn_step)
    );

    // started_q masks the first cycle after reset so a held key is not a press.
    assign fire_press = started_q && (keycode == KEY_FIRE) && (prev_kc_q != KEY_FIRE);

    always_comb begin
        angle_d = angle_q;
        if (up_step && angle_q < ANG_90) begin
            angle_d = angle_q + 4'd1;
        end else if (dn_step && angle_q > ANG_270) begin
            angle_d = angle_q - 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cool_d       = cool_q;
        fire_angle_d = fire_angle_q;
        case (state_q)
            ST_IDLE: begin
                if (fire_press) begin
                    fire_angle_d = angle_q;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fire_ack) state_d = ST_FLIGHT;
            end
            ST_FLIGHT: begin
                if (proj_done) begin
                    state_d = ST_COOL;
                    cool_d  = COOL_LOAD;
                end
            end
            ST_COOL: begin
                if (frame_tick) begin
                    cool_d = cool_q - 8'd1;
                    if (cool_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        onehot_d   = angle_to_onehot(angle_d);
        fire_req_d = (state_d == ST_REQ);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_kc_q    <= KEY_NONE;
            started_q    <= 1'b0;
            state_q      <= ST_IDLE;
            cool_q       <= 8'd0;
            angle_q      <= ANG_0;
            fire_angle_q <= ANG_0;
            onehot_q     <= angle_to_onehot(ANG_0);
            fire_req_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            prev_kc_q    <= keycode;
            started_q    <= 1'b1;
            state_q      <= state_d;
            cool_q       <= cool_d;
            angle_q      <= angle_d;
            fire_angle_q <= fire_angle_d;
            onehot_q     <= onehot_d;
            fire_req_q   <= fire_req_d;
            busy_q       <= busy_d;
        end
    end

    assign angle_idx    = angle_q;
    assign angle_onehot = onehot_q;
    assign fire_req     = fire_req_q;
    assign fire_angle   = fire_angle_q;
    assign busy         = busy_q;

endmodule

// File: doc/turret_fire_ctrl.md
TURRET_FIRE_CTRL -- requirements
Module: turret_fire_ctrl

Interface
REQ-001 Parameter KEY_UP, default 8'h1A, keycode that raises the turret.
REQ-002 Parameter KEY_DOWN, default 8'h16, keycode that lowers the turret.
REQ-003 Parameter KEY_FIRE, default 8'h2C, keycode that fires.
REQ-004 Parameter REPEAT_FRAMES, default 8, number of frame ticks between auto-repeat steps while a key is held (range 1..255).
REQ-005 Parameter COOLDOWN_FRAMES, default 30, number of frame ticks between projectile end and the next allowed fire (range 1..255).
REQ-006 Clk  in  1  system clock; the single clock; all state updates on posedge Clk.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 keycode  in  8  current key; 8'h00 = no key.
REQ-009 frame_tick  in  1  one-Clk pulse per video frame.
REQ-010 fire_ack  in  1  projectile engine accepts the launch.
REQ-011 proj_done  in  1  one-Clk pulse when the projectile terminates.
REQ-012 angle_idx  out  4  turret angle index 0..8 = 270,300,315,330,0,30,45,60,90 degrees.
REQ-013 angle_onehot  out  9  bit angle_idx is set; all other bits are clear.
REQ-014 fire_req  out  1  launch request to the projectile engine.
REQ-015 fire_angle  out  4  angle index latched at fire; valid while fire_req=1.
REQ-016 busy  out  1  high in every fire state other than IDLE.

Function
REQ-017 Key press detection compares keycode against its value registered on the previous Clk; a press is keycode equal to the key this cycle and not equal to it the previous cycle.
REQ-018 A KEY_UP press increments angle_idx on the next Clk; a KEY_DOWN press decrements it on the next Clk.
REQ-019 While KEY_UP/KEY_DOWN is held, the repeat counter counts frame_ticks; angle_idx steps once every REPEAT_FRAMES ticks after the press; the counter clears on release or on a keycode change.
REQ-020 angle_idx saturates: UP at 8 holds 8, DOWN at 0 holds 0; there is no wrap-around.
REQ-021 Angle stepping is legal in every fire state and never alters fire_angle.
REQ-022 The fire FSM has states IDLE, REQ, FLIGHT, COOL.
REQ-023 IDLE: a KEY_FIRE press latches fire_angle=angle_idx and moves to REQ; holding KEY_FIRE never re-fires without a release.
REQ-024 REQ: fire_req=1 until fire_ack=1 is sampled; fire_req=0 and FLIGHT from the next Clk.
REQ-025 FLIGHT: proj_done moves to COOL and loads cooldown=COOLDOWN_FRAMES.
REQ-026 COOL: each frame_tick decrements cooldown; on the tick where cooldown reaches 0, move to IDLE.
REQ-027 fire_ack outside REQ, proj_done outside FLIGHT, and KEY_FIRE outside IDLE are ignored.
REQ-028 fire_ack and proj_done high together in REQ: move to FLIGHT only; proj_done is dropped.
REQ-029 All outputs are registered; latency from input to output is 1 Clk.

Reset
REQ-030 Reset asserted forces angle_idx=4, angle_onehot=9'b000010000, fire_req=0, fire_angle=4, busy=0, FSM=IDLE, and clears the repeat and cooldown counters and the previous-keycode register.
REQ-031 Reset mid-operation (REQ/FLIGHT/COOL) drops fire_req and busy immediately without waiting for Clk.
REQ-032 After reset release, a key already held is not treated as a press until it is released and pressed again; the previous-keycode register clears to 8'h00, so this case is resolved in favour of "not a press".

Structure
REQ-033 Shared package tank_pkg holds the fire-state enum, the angle index constants (ANG_270..ANG_90), and the key code constants.
REQ-034 One sub-module, key_repeat, performs press detection and frame-based auto-repeat for one key; it is instantiated twice (UP, DOWN).

Verification
REQ-035 Reset, then keycode=8'h1A held for 1 Clk -> angle_idx 4->5, angle_onehot=9'b000100000.
REQ-036 KEY_UP held for 40 frame_ticks from idx 4 -> steps at press and at ticks 8, 16, 24 (idx 8); idx stays 8 afterwards.
REQ-037 KEY_FIRE press at idx 6 -> fire_req=1 with fire_angle=6; fire_ack after 5 Clk -> fire_req=0, state FLIGHT.
REQ-038 proj_done in FLIGHT -> busy stays 1 for 30 frame_ticks, then IDLE; a KEY_FIRE press during COOL produces no fire_req.
REQ-039 fire_ack and proj_done asserted together in REQ -> FLIGHT; a later proj_done is needed to enter COOL.
REQ-040 Reset asserted asynchronously during REQ -> fire_req=0 before the next Clk edge; angle_idx=4.
